// File: rtl/perf_counter_bank_pkg.sv
// Shared types and constants for the performance-counter bank.
// perf_pkg is imported by the interface, the counter and the top level.
package perf_pkg;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        DUMP  = 2'd1,
        DONE  = 2'd2
    } perf_state_t;

    localparam int EVT_RETIRE = 0;
    localparam int EVT_ICREQ  = 1;
    localparam int EVT_ICHIT  = 2;
    localparam int EVT_DCREQ  = 3;
    localparam int EVT_DCHIT  = 4;

    // Index width needed to address NUM_EVT channels plus the cycle counter.
    function automatic int idxWidth(input int numEvt);
        return $clog2(numEvt + 1);
    endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Event/halt inputs and serial dump port of the performance-counter bank.
interface perf_counter_bank_if
    import perf_pkg::*;
#(
    parameter int NUM_EVT = 5,
    parameter int CNT_W   = 32
);
    localparam int IDX_W = idxWidth(NUM_EVT);

    logic [NUM_EVT-1:0] events;
    logic               halt;
    logic               dump_ready;
    logic               dump_valid;
    logic [IDX_W-1:0]   dump_idx;
    logic [CNT_W-1:0]   dump_data;
    logic               dump_done;
    logic [CNT_W-1:0]   cycle_count;

    modport master (
        output events, halt, dump_ready,
        input  dump_valid, dump_idx, dump_data, dump_done, cycle_count
    );

    modport slave (
        input  events, halt, dump_ready,
        output dump_valid, dump_idx, dump_data, dump_done, cycle_count
    );

endinterface

// File: rtl/perf_counter.sv
// Single event counter with increment, freeze, synchronous clear and optional
// saturation; the sticky overflow flag exists only with PERF_CNT_OVF_EN.
module perf_counter
    import perf_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cntNext
`ifdef PERF_CNT_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cntNext_s;
    logic             allOnes_s;
    logic             step_s;

    // Next-count computation: wrap or clamp at all-ones.
    always_comb begin
        allOnes_s = &cnt_r;
        step_s    = inc & ~freeze;
        cntNext_s = cnt_r;
        if (step_s) begin
            if ((SATURATE != 0) && allOnes_s) begin
                cntNext_s = cnt_r;
            end else begin
                cntNext_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cntNext_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cntNext_s;
        end
    end

    assign cnt     = cnt_r;
    assign cntNext = cntNext_s;

`ifdef PERF_CNT_OVF_EN
    logic ovf_r;

    // Sticky overflow: an event arrives while the count is already all-ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            ovf_r <= 1'b0;
        end else if (step_s && allOnes_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Event-counter bank: counts strobes and cycles, then serially dumps all counts
// after halt. Define PERF_CNT_OVF_EN to add the sticky per-channel ovf flags.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_EVT  = 5,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    perf_counter_bank_if.slave bus
`ifdef PERF_CNT_OVF_EN
    ,
    output logic [NUM_EVT-1:0] ovf
`endif
);

    localparam int IDX_W = idxWidth(NUM_EVT);

    localparam logic [1:0] ST_COUNT = COUNT;
    localparam logic [1:0] ST_DUMP  = DUMP;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]       state_r;
    logic [IDX_W-1:0] ptr_r;
    logic             dumpValid_r;
    logic             dumpDone_r;
    logic [CNT_W-1:0] dumpData_r;

    logic [CNT_W-1:0] cnt_s     [NUM_EVT+1];
    logic [CNT_W-1:0] cntNext_s [NUM_EVT+1];
    logic             freeze_s;
    logic             xfer_s;
    logic             lastPtr_s;
    logic [IDX_W-1:0] ptrInc_s;
    logic [IDX_W-1:0] selIdx_s;
    logic [CNT_W-1:0] selData_s;

`ifdef PERF_CNT_OVF_EN
    logic [NUM_EVT:0] ovfAll_s;
`endif

    assign freeze_s = (state_r != ST_COUNT);

    // Channels 0..NUM_EVT-1 follow their strobes; the last one counts cycles.
    for (genvar g = 0; g <= NUM_EVT; g++) begin : gCnt
        logic inc_s;
        if (g < NUM_EVT) begin : gEvt
            assign inc_s = bus.events[g];
        end else begin : gCyc
            assign inc_s = 1'b1;
        end

        perf_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) uCnt (
            .clk     (clk),
            .clr     (rst),
            .inc     (inc_s),
            .freeze  (freeze_s),
            .cnt     (cnt_s[g]),
            .cntNext (cntNext_s[g])
`ifdef PERF_CNT_OVF_EN
            ,
            .ovf     (ovfAll_s[g])
`endif
        );
    end

    // Pick the next dump word: channel 0 as it will be after the halt edge,
    // or the frozen count following the word currently on the port.
    always_comb begin
        xfer_s    = dumpValid_r & bus.dump_ready;
        lastPtr_s = (ptr_r == IDX_W'(NUM_EVT));
        ptrInc_s  = ptr_r + IDX_W'(1);
        if (state_r == ST_COUNT) begin
            selIdx_s = IDX_W'(0);
        end else begin
            selIdx_s = ptrInc_s;
        end
        selData_s = '0;
        for (int k = 0; k <= NUM_EVT; k++) begin
            if (IDX_W'(k) == selIdx_s) begin
                selData_s = (state_r == ST_COUNT) ? cntNext_s[k] : cnt_s[k];
            end else begin
                selData_s = selData_s;
            end
        end
    end

    // Control FSM, dump pointer and registered dump outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_COUNT;
            ptr_r       <= '0;
            dumpValid_r <= 1'b0;
            dumpDone_r  <= 1'b0;
            dumpData_r  <= '0;
        end else begin
            case (state_r)
                ST_COUNT: begin
                    if (bus.halt) begin
                        state_r     <= ST_DUMP;
                        ptr_r       <= '0;
                        dumpValid_r <= 1'b1;
                        dumpData_r  <= selData_s;
                    end else begin
                        state_r <= ST_COUNT;
                    end
                end
                ST_DUMP: begin
                    if (xfer_s && lastPtr_s) begin
                        state_r     <= ST_DONE;
                        dumpValid_r <= 1'b0;
                        dumpDone_r  <= 1'b1;
                    end else if (xfer_s) begin
                        ptr_r      <= ptrInc_s;
                        dumpData_r <= selData_s;
                    end else begin
                        state_r <= ST_DUMP;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r     <= ST_COUNT;
                    ptr_r       <= '0;
                    dumpValid_r <= 1'b0;
                    dumpDone_r  <= 1'b0;
                    dumpData_r  <= '0;
                end
            endcase
        end
    end

    assign bus.dump_valid  = dumpValid_r;
    assign bus.dump_idx    = ptr_r;
    assign bus.dump_data   = dumpData_r;
    assign bus.dump_done   = dumpDone_r;
    assign bus.cycle_count = cnt_s[NUM_EVT];

`ifdef PERF_CNT_OVF_EN
    assign ovf = ovfAll_s[NUM_EVT-1:0];
`endif

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised, synthesizable event-counter bank that replaces the simulation-only instruction/cache-hit tallies in the processor bench with hardware counters. It counts up to NUM_EVT single-bit event strobes (retire, I-cache request/hit, D-cache request/hit, …) plus a free-running cycle count. On halt it freezes and serially dumps every count over a valid/ready port. It sits beside the processor core, is fed from pipeline/cache strobes, and is drained by the bench or a debug unit.

## Interface
Parameters:
- NUM_EVT, default 5: number of event channels, 1..16.
- CNT_W, default 32: counter width for every channel and for the cycle counter, 8..64.
- SATURATE, default 0: 0 means counters wrap modulo 2^CNT_W; 1 means counters clamp at all-ones.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- events  in  NUM_EVT  per-channel event strobe; bit i counts once per cycle when high.
- halt  in  1  processor halted; sampled only in COUNT.
- dump_ready  in  1  consumer accepts the current dump word.
- dump_valid  out  1  dump word present.
- dump_idx  out  IDX_W  channel index of the dump word; IDX_W = $clog2(NUM_EVT+1).
- dump_data  out  CNT_W  count for dump_idx.
- dump_done  out  1  all words transferred.
- cycle_count  out  CNT_W  live cycle counter.
- ovf  out  NUM_EVT  sticky overflow flags; present only with PERF_CNT_OVF_EN.

## Operation
- States: COUNT (reset state), DUMP, DONE.
- COUNT: cycle_count += 1 every cycle; cnt[i] += 1 for each events[i]=1.
- halt=1 in COUNT: that cycle's events and cycle are still counted; next state DUMP; ptr := 0.
- DUMP: counters frozen, events ignored. dump_valid=1, dump_idx=ptr, dump_data = cnt[ptr] for ptr<NUM_EVT, else cycle_count (ptr==NUM_EVT).
- Transfer occurs when dump_valid & dump_ready. ptr increments on transfer. Transfer at ptr==NUM_EVT leads to DONE.
- dump_ready low stalls; dump_idx and dump_data hold stable while valid is unaccepted.
- DONE: dump_valid=0, dump_done=1; state held until rst. halt is ignored outside COUNT.
- Arithmetic, SATURATE=0: all-ones + 1 gives 0. SATURATE=1: all-ones + 1 gives all-ones. Same rules apply to cycle_count.
- Reset values: all counters 0, ptr 0, state COUNT, dump_valid 0, dump_done 0, dump_idx 0, dump_data 0, ovf 0.

## Timing
- Count latency: an event at cycle n is visible in cnt/cycle_count after edge n (1 cycle).
- If halt is sampled at the edge ending cycle k (k = 1 is the first cycle with rst low), dump_valid rises in cycle k+1, and the first word shows cycle_count = k.
- Minimum dump length with ready held high: NUM_EVT+1 cycles. dump_done rises the cycle after the final transfer.
- rst mid-DUMP or in DONE: next cycle is COUNT with all state zeroed. No partial transfer is completed.
- halt and rst both high: rst wins.

## Configuration
- PERF_CNT_OVF_EN defined: ovf port exists. ovf[i] sets when events[i]=1 in COUNT while cnt[i] is all-ones, in either SATURATE mode. The flag is sticky until rst. In DUMP, dump_data for a channel is unaffected by its flag.
- PERF_CNT_OVF_EN undefined: no ovf port and no flag registers. Everything else is identical.

## Structure
- Shared package perf_pkg holds:
  - state typedef perf_state_t {COUNT, DUMP, DONE};
  - default event index constants EVT_RETIRE=0, EVT_ICREQ=1, EVT_ICHIT=2, EVT_DCREQ=3, EVT_DCHIT=4.
- One sub-module, perf_counter: a single CNT_W counter with inc/freeze/clear and SATURATE, plus an optional overflow flag. It is instantiated NUM_EVT+1 times; instance NUM_EVT is the cycle counter with inc tied to 1.
- The top level holds the FSM, ptr, and dump mux.

## Test plan
- Basic count: NUM_EVT=5, CNT_W=32. After reset, pulse events=5'b00001 for 10 cycles and events=5'b10100 for 3 cycles, then halt. Required dump with dump_ready=1: idx0=10, idx2=3, idx4=3, idx1=idx3=0, idx5=14. dump_done 6 cycles after halt.
- Backpressure: dump_ready toggled 1,0,0,1,…. dump_idx/dump_data stable during stalls. Each index appears exactly once, in order 0..5.
- Wrap vs saturate: CNT_W=8, channel 0 high for 300 cycles. SATURATE=0 dumps 44; SATURATE=1 dumps 255. With PERF_CNT_OVF_EN, ovf[0]=1 in both modes and ovf[4:1]=0.
- Freeze: events all-ones during DUMP and DONE. Dumped values equal the counts at the halt cycle; cycle_count does not advance after halt.
- Reset mid-dump: rst after 2 transfers. Next cycle: state COUNT, dump_valid=0, all counts 0. A second run of 4 cycles, then halt, dumps cycle_count=5.
- Halt ignored in DONE: a second halt pulse after dump_done causes no dump_valid and dump_done stays 1.
